svc_rv_dbg_host: RTL and testbench
==================================

# svc_rv_dbg_host

Hardware initiator for the RISC-V debug-bridge UART protocol. It accepts word-level debug commands (write word, control stall/reset) on a valid/ready port and serializes each one into a 9-byte frame on a byte stream. It then waits for the bridge's 1-byte acknowledge and returns a status. It sits between a boot source (flash streamer, test sequencer) and a `svc_uart_tx`/`svc_uart_rx` pair, or connects directly to the SoC's `dbg_urx_*`/`dbg_utx_*` pins, so a program can be loaded without the host script.

## Interface
- `ACK_TIMEOUT`, 1_000_000: cycles to wait for the ack byte before reporting timeout; must be ≥ 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_op` in 8: opcode, `OP_WRITE`=0x01 or `OP_CTRL`=0x02.
- `cmd_addr` in 32: target byte address; ignored-but-sent for `OP_CTRL`.
- `cmd_data` in 32: write data; for `OP_CTRL`, bit0 = stall, bit1 = cpu reset.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_status` out 2: `ST_OK`=0, `ST_NAK`=1, `ST_TIMEOUT`=2.
- `utx_valid` / `utx_data[7:0]` out, `utx_ready` in: frame bytes toward the bridge.
- `urx_valid` / `urx_data[7:0]` in, `urx_ready` out: bytes from the bridge.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame layout: byte0 = op, bytes1–4 = addr (LSB first), bytes5–8 = data (LSB first). The ack byte is 0x06 = OK; any other value = NAK.
- FSM states: IDLE, SEND, WAIT_ACK, RESP.
  - IDLE: `cmd_ready`=1 and `urx_ready`=1. Stray rx bytes are consumed and dropped. On a `cmd` handshake, latch op/addr/data, set byte index to 0, and go to SEND.
  - SEND: `utx_valid`=1 and `utx_data` = frame[idx]. On a `utx` handshake, idx += 1. The handshake at idx 8 moves to WAIT_ACK. `urx_ready`=0.
  - WAIT_ACK: `urx_ready`=1 and the timeout counter runs. On a `urx` handshake, status = OK if data is 0x06, else NAK, then go to RESP. When the counter reaches `ACK_TIMEOUT`-1 with no ack, status = TIMEOUT and go to RESP.
  - RESP: `rsp_valid`=1, and `rsp_status` stays stable until the `rsp` handshake, then go to IDLE. `urx_ready`=0.
- Only one command is in flight; `cmd_ready` is 0 outside IDLE.
- An ack and the timeout expiring in the same cycle: the ack wins.
- The byte index is 4 bits and saturates at no value beyond 8; the counter is `$clog2(ACK_TIMEOUT)` bits and clears on every entry to WAIT_ACK.
- A reset mid-frame abandons the frame; no partial response is produced.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from `*_valid` or `*_ready` inputs to outputs.
- Reset values: state IDLE; `cmd_ready`=1 (decode of IDLE); `utx_valid`=0, `utx_data`=0, `urx_ready`=1, `rsp_valid`=0, `rsp_status`=0, `busy`=0.
- `cmd` handshake at cycle T gives `utx_valid`=1 with the op byte at T+1.
- Held `utx_data` changes only after a handshake. With `utx_ready` tied high, the 9 bytes occupy cycles T+1..T+9.
- An ack byte accepted at cycle A gives `rsp_valid` at A+1. After the `rsp` handshake at R, `cmd_ready`=1 at R+1.
- Best case, command to response: 11 cycles.
- Timeout: with no ack, `rsp_valid` rises exactly `ACK_TIMEOUT` cycles after the final `utx` handshake.

## Configuration
- `SVC_RV_DBG_HOST_TIMEOUT_EN`:
  - Defined: the timeout counter and the `ST_TIMEOUT` path are built.
  - Undefined: no counter exists, WAIT_ACK waits indefinitely, `ST_TIMEOUT` is never produced, and `ACK_TIMEOUT` is ignored.

## Structure
- The shared package `svc_rv_dbg_pkg` holds the opcodes `OP_WRITE`/`OP_CTRL`, `ACK_OK`=0x06, the `dbg_status_t` enum, the frame length 9, and the CTRL bit positions. The debug bridge uses the same package.
- A single sub-module is natural: `svc_rv_dbg_host_ser`, a 9-byte shift/index serializer holding the latched frame with a valid/ready byte output. The FSM and timeout logic stay in the top.

## Test plan
- Write with `utx_ready`=1: op 0x01, addr 0x0000_0010, data 0xDEAD_BEEF → bytes 01 10 00 00 00 EF BE AD DE; ack 0x06 → `rsp_status`=OK one cycle later.
- Backpressure: toggle `utx_ready` every other cycle → same 9 bytes with no duplicates or skips, and `utx_data` stable while stalled.
- NAK: op 0x02, data 0x3; bridge replies 0x15 → `rsp_status`=NAK; `cmd_ready` returns the cycle after `rsp_ready`.
- Timeout (macro defined, `ACK_TIMEOUT`=16): no ack → `rsp_status`=TIMEOUT exactly 16 cycles after the last byte. An ack arriving on cycle 16 → OK.
- Stray rx byte 0x06 in IDLE is dropped; the next command still needs its own ack.
- Assert `rst_n` low after byte 4 → outputs return to reset values immediately. After release, a new command sends a full 9-byte frame.

Source files
------------

// File: rtl/svc_rv_dbg_pkg.sv
// Shared definitions for the RISC-V debug-bridge UART protocol: opcodes,
// acknowledge byte, frame geometry, CTRL bit positions and status codes.
package svc_rv_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_CTRL  = 8'h02;
  localparam logic [7:0] ACK_OK   = 8'h06;

  localparam int FRAME_LEN      = 9;
  localparam int CTRL_STALL_BIT = 0;
  localparam int CTRL_RESET_BIT = 1;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NAK     = 2'd1,
    ST_TIMEOUT = 2'd2
  } dbg_status_t;

  typedef enum logic [1:0] {
    HOST_IDLE     = 2'd0,
    HOST_SEND     = 2'd1,
    HOST_WAIT_ACK = 2'd2,
    HOST_RESP     = 2'd3
  } host_state_t;

  // Any byte other than the OK code counts as a negative acknowledge.
  function automatic dbg_status_t ack_to_status(input logic [7:0] ack);
    dbg_status_t st;
    if (ack == ACK_OK) begin
      st = ST_OK;
    end else begin
      st = ST_NAK;
    end
    return st;
  endfunction

endpackage

// File: rtl/svc_rv_dbg_host_ser.sv
// 9-byte frame serializer for svc_rv_dbg_host. Holds the latched command
// as {data, addr} behind the current byte and shifts one byte out per
// accepted transfer. The current byte is a register, so it stays stable
// while the consumer stalls.
module svc_rv_dbg_host_ser
  import svc_rv_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_advance,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic [7:0]  r_byte;
  logic [63:0] r_rest;
  logic [3:0]  r_idx;

  // Load a new frame, or step to the next byte on each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte <= 8'h00;
      r_rest <= 64'h0;
      r_idx  <= 4'd0;
    end else if (i_load) begin
      r_byte <= i_op;
      r_rest <= {i_data, i_addr};
      r_idx  <= 4'd0;
    end else if (i_advance) begin
      if (r_idx == LAST_IDX) begin
        // Frame done: idle the byte lane and keep the index pinned at 8.
        r_byte <= 8'h00;
        r_rest <= 64'h0;
        r_idx  <= LAST_IDX;
      end else begin
        r_byte <= r_rest[7:0];
        r_rest <= {8'h00, r_rest[63:8]};
        r_idx  <= r_idx + 4'd1;
      end
    end else begin
      r_byte <= r_byte;
      r_rest <= r_rest;
      r_idx  <= r_idx;
    end
  end

  assign o_byte = r_byte;
  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/svc_rv_dbg_host.sv
// Debug-bridge host: turns word-level debug commands into 9-byte UART
// frames, then waits for the bridge's 1-byte acknowledge and reports a
// status. Optional feature macro: SVC_RV_DBG_HOST_TIMEOUT_EN builds the
// ack timeout counter (ACK_TIMEOUT cycles, must be >= 2); without it the
// host waits for the ack indefinitely.
module svc_rv_dbg_host #(
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_op,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [1:0]  o_rsp_status,
  output logic        o_utx_valid,
  output logic [7:0]  o_utx_data,
  input  logic        i_utx_ready,
  input  logic        i_urx_valid,
  input  logic [7:0]  i_urx_data,
  output logic        o_urx_ready,
  output logic        o_busy
);

  import svc_rv_dbg_pkg::*;

  host_state_t r_state;
  host_state_t w_state_nxt;
  dbg_status_t r_status;
  dbg_status_t w_status_nxt;
  logic        w_load;
  logic        w_advance;
  logic        w_enter_wait;
  logic        w_timeout;
  logic        w_last;
  logic [7:0]  w_byte;

  svc_rv_dbg_host_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_op      (i_cmd_op),
    .i_addr    (i_cmd_addr),
    .i_data    (i_cmd_data),
    .i_advance (w_advance),
    .o_byte    (w_byte),
    .o_last    (w_last)
  );

`ifdef SVC_RV_DBG_HOST_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count cycles spent in WAIT_ACK; cleared on every entry to that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(0);
    end else if (w_enter_wait) begin
      r_cnt <= CNT_W'(0);
    end else if ((r_state == HOST_WAIT_ACK) && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_timeout = (r_state == HOST_WAIT_ACK) && (r_cnt == CNT_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (ACK_TIMEOUT > 1);
  assign w_timeout        = 1'b0;
`endif

  // State and latched response status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HOST_IDLE;
      r_status <= ST_OK;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
    end
  end

  // Next-state, status update and serializer control.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_enter_wait = 1'b0;
    case (r_state)
      HOST_IDLE: begin
        // Stray rx bytes are accepted here (urx_ready=1) and dropped.
        if (i_cmd_valid) begin
          w_load      = 1'b1;
          w_state_nxt = HOST_SEND;
        end else begin
          w_state_nxt = HOST_IDLE;
        end
      end
      HOST_SEND: begin
        if (i_utx_ready) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_enter_wait = 1'b1;
            w_state_nxt  = HOST_WAIT_ACK;
          end else begin
            w_state_nxt = HOST_SEND;
          end
        end else begin
          w_state_nxt = HOST_SEND;
        end
      end
      HOST_WAIT_ACK: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (i_urx_valid) begin
          w_status_nxt = ack_to_status(i_urx_data);
          w_state_nxt  = HOST_RESP;
        end else if (w_timeout) begin
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = HOST_RESP;
        end else begin
          w_state_nxt = HOST_WAIT_ACK;
        end
      end
      HOST_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = HOST_IDLE;
        end else begin
          w_state_nxt = HOST_RESP;
        end
      end
      default: begin
        w_state_nxt = HOST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the state register only.
  assign o_cmd_ready  = (r_state == HOST_IDLE);
  assign o_utx_valid  = (r_state == HOST_SEND);
  assign o_utx_data   = w_byte;
  assign o_urx_ready  = (r_state == HOST_IDLE) || (r_state == HOST_WAIT_ACK);
  assign o_rsp_valid  = (r_state == HOST_RESP);
  assign o_rsp_status = r_status;
  assign o_busy       = (r_state != HOST_IDLE);

endmodule

// File: tb/tb_svc_rv_dbg_host.sv
// Directed bench for svc_rv_dbg_host with a byte/status scoreboard.
module tb_svc_rv_dbg_host;

  localparam logic [1:0] EXP_OK  = 2'd0;
  localparam logic [1:0] EXP_NAK = 2'd1;
  localparam logic [1:0] EXP_TO  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid, o_cmd_ready;
  logic [7:0]  i_cmd_op;
  logic [31:0] i_cmd_addr, i_cmd_data;
  logic        o_rsp_valid, i_rsp_ready;
  logic [1:0]  o_rsp_status;
  logic        o_utx_valid, i_utx_ready;
  logic [7:0]  o_utx_data;
  logic        i_urx_valid, o_urx_ready;
  logic [7:0]  i_urx_data;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_bytes[$];
  logic [1:0] q_status[$];
  int         n_bytes_seen = 0;
  int         frame_base = 0;
  logic       held_pending = 1'b0;
  logic [7:0] held_byte = 8'h00;

  svc_rv_dbg_host #(.ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_data   (i_cmd_data),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_status (o_rsp_status),
    .o_utx_valid  (o_utx_valid),
    .o_utx_data   (o_utx_data),
    .i_utx_ready  (i_utx_ready),
    .i_urx_valid  (i_urx_valid),
    .i_urx_data   (i_urx_data),
    .o_urx_ready  (o_urx_ready),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"},  {31'd0, o_cmd_ready},  32'd1);
    chk({tag, "_utx_valid"},  {31'd0, o_utx_valid},  32'd0);
    chk({tag, "_utx_data"},   {24'd0, o_utx_data},   32'd0);
    chk({tag, "_urx_ready"},  {31'd0, o_urx_ready},  32'd1);
    chk({tag, "_rsp_valid"},  {31'd0, o_rsp_valid},  32'd0);
    chk({tag, "_rsp_status"}, {30'd0, o_rsp_status}, 32'd0);
    chk({tag, "_busy"},       {31'd0, o_busy},       32'd0);
  endtask

  // Byte monitor: judges each transfer at the negedge before its accepting edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_utx_valid) begin
        if (held_pending) chk("utx_hold", {24'd0, o_utx_data}, {24'd0, held_byte});
        if (i_utx_ready) begin
          n_tests++;
          assert (q_bytes.size() != 0) else begin
            n_fail++;
            $error("FAIL utx_extra: observed byte %0h expected no byte", o_utx_data);
          end
          if (q_bytes.size() != 0) chk("utx_byte", {24'd0, o_utx_data}, {24'd0, q_bytes.pop_front()});
          n_bytes_seen++;
          held_pending = 1'b0;
        end else begin
          held_pending = 1'b1;
          held_byte    = o_utx_data;
        end
      end else begin
        held_pending = 1'b0;
      end
    end
  end

  // Offer one command in IDLE and check the op byte appears next cycle.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    chk("cmd_ready_idle", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    q_bytes.push_back(op);
    for (int i = 0; i < 4; i++) q_bytes.push_back(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) q_bytes.push_back(data[8*i +: 8]);
    frame_base = n_bytes_seen;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk("first_valid", {31'd0, o_utx_valid}, 32'd1);
    chk("first_op", {24'd0, o_utx_data}, {24'd0, op});
    chk("cmd_ready_busy", {31'd0, o_cmd_ready}, 32'd0);
  endtask

  // Clock bytes out (optionally toggling utx_ready); returns cycles used.
  task automatic run_frame(input bit bp, input int nbytes, output int cyc);
    cyc = 0;
    while ((n_bytes_seen < frame_base + nbytes) && (cyc < 200)) begin
      i_utx_ready = bp ? cyc[0] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    i_utx_ready = 1'b1;
    chk("frame_bytes", n_bytes_seen - frame_base, nbytes);
  endtask

  task automatic send_ack(input logic [7:0] ack, input logic [1:0] exp_st);
    chk("ack_rsp_idle", {31'd0, o_rsp_valid}, 32'd0);
    chk("ack_urx_ready", {31'd0, o_urx_ready}, 32'd1);
    i_urx_valid = 1'b1;
    i_urx_data  = ack;
    q_status.push_back(exp_st);
    @(posedge clk); #1;
    i_urx_valid = 1'b0;
    chk("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    chk("rsp_status", {30'd0, o_rsp_status}, {30'd0, q_status.pop_front()});
    chk("rsp_urx_ready", {31'd0, o_urx_ready}, 32'd0);
  endtask

  // Hold rsp_ready low for two cycles, then complete the response.
  task automatic finish_rsp();
    logic [1:0] st;
    st = o_rsp_status;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("rsp_hold_status", {30'd0, o_rsp_status}, {30'd0, st});
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk("done_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("done_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("done_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int k;
    i_cmd_valid = 1'b0; i_cmd_op = 8'h00; i_cmd_addr = 32'h0; i_cmd_data = 32'h0;
    i_rsp_ready = 1'b0; i_utx_ready = 1'b1; i_urx_valid = 1'b0; i_urx_data = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, no backpressure, OK ack
    issue(8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
    run_frame(1'b0, 9, cyc);
    chk("t1_cycles", cyc, 32'd9);
    chk("t1_wait_busy", {31'd0, o_busy}, 32'd1);
    chk("t1_wait_utx", {31'd0, o_utx_valid}, 32'd0);
    send_ack(8'h06, EXP_OK);
    finish_rsp();

    // Same frame under utx backpressure
    issue(8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
    run_frame(1'b1, 9, cyc);
    chk("bp_cycles", cyc, 32'd18);
    send_ack(8'h06, EXP_OK);
    finish_rsp();

    // CTRL command answered with NAK
    issue(8'h02, 32'h0000_0000, 32'h0000_0003);
    run_frame(1'b0, 9, cyc);
    send_ack(8'h15, EXP_NAK);
    finish_rsp();

    // Stray ack in IDLE is dropped; next command needs its own ack
    chk("stray_urx_ready", {31'd0, o_urx_ready}, 32'd1);
    i_urx_valid = 1'b1;
    i_urx_data  = 8'h06;
    @(posedge clk); #1;
    i_urx_valid = 1'b0;
    chk("stray_rsp", {31'd0, o_rsp_valid}, 32'd0);
    chk("stray_busy", {31'd0, o_busy}, 32'd0);
    issue(8'h01, 32'h1234_5678, 32'h0BAD_F00D);
    run_frame(1'b0, 9, cyc);
    repeat (5) @(posedge clk);
    #1;
    chk("stray_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    send_ack(8'h06, EXP_OK);
    finish_rsp();

`ifdef SVC_RV_DBG_HOST_TIMEOUT_EN
    // No ack: timeout 16 edges after the last byte's accepting edge
    issue(8'h01, 32'h0000_0020, 32'h0000_0001);
    run_frame(1'b0, 9, cyc);
    q_status.push_back(EXP_TO);
    k = 0;
    while ((o_rsp_valid !== 1'b1) && (k < 100)) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_latency", k, 32'd16);
    chk("timeout_status", {30'd0, o_rsp_status}, {30'd0, q_status.pop_front()});
    finish_rsp();

    // Ack on the same edge the timeout would fire: ack wins
    issue(8'h01, 32'h0000_0024, 32'h0000_0002);
    run_frame(1'b0, 9, cyc);
    repeat (15) @(posedge clk);
    #1;
    send_ack(8'h06, EXP_OK);
    finish_rsp();
`else
    // Without the timeout feature the host waits for the ack indefinitely
    issue(8'h01, 32'h0000_0020, 32'h0000_0001);
    run_frame(1'b0, 9, cyc);
    repeat (40) @(posedge clk);
    #1;
    chk("no_timeout_rsp", {31'd0, o_rsp_valid}, 32'd0);
    chk("no_timeout_busy", {31'd0, o_busy}, 32'd1);
    send_ack(8'h06, EXP_OK);
    finish_rsp();
`endif

    // Reset after byte 4 abandons the frame
    issue(8'h01, 32'hA5A5_0004, 32'h5A5A_0008);
    run_frame(1'b0, 4, cyc);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    q_bytes.delete();
    q_status.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_rsp", {31'd0, o_rsp_valid}, 32'd0);
    issue(8'h01, 32'h0000_0040, 32'hCAFE_0001);
    run_frame(1'b0, 9, cyc);
    chk("post_reset_cycles", cyc, 32'd9);
    send_ack(8'h06, EXP_OK);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
